// File: rtl/kgprisc_multicycle_sequencer.sv
// Multi-cycle instruction sequencer for KGPRISC: walks each instruction through
// fetch/decode/execute/memory/writeback, gates control strobes and counts retired instructions.
module kgprisc_multicycle_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_incr,
  output logic             pc_load,
  output logic             alu_en,
  output logic             reg_write_en,
  output logic             mem_to_reg,
  output logic             link_sel,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExec, StMem, StWb, StBranch, StLink, StHalt, StError
  } state_e;

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ill_q, ill_d;
  logic             merr_q, merr_d;
  logic             retire, waiting;
  logic [2:0]       cls;

  assign cls = opcode[7:5];

  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    merr_d  = merr_q;
    retire  = 1'b0;
    waiting = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StError;
          merr_d  = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      StDecode: begin
        case (cls)
          3'b000, 3'b001, 3'b010: state_d = StExec;
          3'b011:                 state_d = StBranch;
          3'b100:                 state_d = StLink;
          3'b101: begin
            state_d = StHalt;
            retire  = 1'b1;
          end
          default: begin
            state_d = StError;
            ill_d   = 1'b1;
          end
        endcase
      end
      StExec: state_d = (cls == 3'b010) ? StMem : StWb;
      StMem: begin
        // Completion wins over timeout in the final waiting cycle.
        if (mem_ready) begin
          if (opcode[0]) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StError;
          merr_d  = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      StWb, StBranch, StLink: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt, StError: state_d = state_q;
      default: state_d = StFetch;
    endcase
    wait_d  = waiting ? wait_q + 8'd1 : 8'd0;
    count_d = (retire && (count_q != {CNT_W{1'b1}})) ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= 8'd0;
      count_q <= '0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
    end
  end

  // State decodes are forced low while rst is held, since FETCH would otherwise request memory.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_incr      = 1'b0;
    pc_load      = 1'b0;
    alu_en       = 1'b0;
    reg_write_en = 1'b0;
    mem_to_reg   = 1'b0;
    link_sel     = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_incr  = mem_ready;
        end
        StExec: alu_en = 1'b1;
        StMem: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = opcode[0];
        end
        StWb: begin
          reg_write_en = 1'b1;
          mem_to_reg   = (cls == 3'b010);
        end
        StBranch: pc_load = branch_taken;
        StLink: begin
          reg_write_en = 1'b1;
          link_sel     = 1'b1;
          pc_load      = 1'b1;
        end
        StHalt, StError: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_op  = ill_q;
  assign mem_err     = merr_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_kgprisc_multicycle_sequencer.sv
// Cycle-level bench: vector tables of inputs and expected strobes checked through a scoreboard.
module tb_kgprisc_multicycle_sequencer;

  // Expected strobe vector bit order:
  // mem_req mem_we mem_addr_sel ir_write pc_incr pc_load alu_en reg_write_en
  // mem_to_reg link_sel halted illegal_op mem_err
  localparam logic [12:0] FW  = 13'h1000;
  localparam logic [12:0] FR  = 13'h1300;
  localparam logic [12:0] DEC = 13'h0000;
  localparam logic [12:0] EX  = 13'h0040;
  localparam logic [12:0] MRD = 13'h1400;
  localparam logic [12:0] MWR = 13'h1C00;
  localparam logic [12:0] WBA = 13'h0020;
  localparam logic [12:0] WBL = 13'h0030;
  localparam logic [12:0] BRT = 13'h0080;
  localparam logic [12:0] BRN = 13'h0000;
  localparam logic [12:0] LNK = 13'h00A8;
  localparam logic [12:0] HLT = 13'h0004;
  localparam logic [12:0] ERI = 13'h0006;
  localparam logic [12:0] ERM = 13'h0005;

  typedef struct {
    logic [7:0]  op;
    logic        bt;
    logic        rdy;
    logic [12:0] exp;
    int unsigned cnt;
    string       name;
  } vec_t;

  logic        clk, rst;
  logic [7:0]  opcode;
  logic        branch_taken, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_incr, pc_load, alu_en;
  logic        reg_write_en, mem_to_reg, link_sel, halted, illegal_op, mem_err;
  logic [15:0] instr_count;

  logic        s_mem_req, s_mem_we, s_mem_addr_sel, s_ir_write, s_pc_incr, s_pc_load;
  logic        s_alu_en, s_reg_write_en, s_mem_to_reg, s_link_sel, s_halted;
  logic        s_illegal_op, s_mem_err;
  logic [3:0]  s_instr_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  vec_t        tbl[$];
  vec_t        sb[$];

  kgprisc_multicycle_sequencer #(.CNT_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_incr(pc_incr),
    .pc_load(pc_load), .alu_en(alu_en), .reg_write_en(reg_write_en),
    .mem_to_reg(mem_to_reg), .link_sel(link_sel), .halted(halted),
    .illegal_op(illegal_op), .mem_err(mem_err), .instr_count(instr_count)
  );

  kgprisc_multicycle_sequencer #(.CNT_W(4), .MAX_WAIT(15)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_addr_sel(s_mem_addr_sel), .ir_write(s_ir_write), .pc_incr(s_pc_incr),
    .pc_load(s_pc_load), .alu_en(s_alu_en), .reg_write_en(s_reg_write_en),
    .mem_to_reg(s_mem_to_reg), .link_sel(s_link_sel), .halted(s_halted),
    .illegal_op(s_illegal_op), .mem_err(s_mem_err), .instr_count(s_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {mem_req, mem_we, mem_addr_sel, ir_write, pc_incr, pc_load, alu_en,
            reg_write_en, mem_to_reg, link_sel, halted, illegal_op, mem_err};
  endfunction

  task automatic check(input string name, input logic [12:0] exp, input int unsigned cnt);
    n_tests++;
    if (outs() !== exp || instr_count !== 16'(cnt)) begin
      n_fail++;
      $display("FAIL %s: outs=%013b count=%0d, required outs=%013b count=%0d",
               name, outs(), instr_count, exp, cnt);
    end
  endtask

  task automatic add(input logic [7:0] op, input logic bt, input logic rdy,
                     input logic [12:0] exp, input int unsigned cnt, input string name);
    vec_t v;
    v.op = op; v.bt = bt; v.rdy = rdy; v.exp = exp; v.cnt = cnt; v.name = name;
    tbl.push_back(v);
  endtask

  // Called at a falling edge; drives one cycle, checks it, returns at the next falling edge.
  task automatic step(input vec_t v);
    vec_t e;
    opcode = v.op; branch_taken = v.bt; mem_ready = v.rdy;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check(e.name, e.exp, e.cnt);
    @(negedge clk);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    check("reset_outputs", 13'h0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = 8'h00; branch_taken = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // ALU, load with waits, store, branch taken/not, branch-and-link, halt
    add(8'h01, 0, 1, FR,  0, "alu_fetch");   add(8'h01, 0, 1, DEC, 0, "alu_decode");
    add(8'h01, 0, 1, EX,  0, "alu_exec");    add(8'h01, 0, 1, WBA, 0, "alu_wb");
    add(8'h40, 0, 0, FW,  1, "ld_fwait1");   add(8'h40, 0, 0, FW,  1, "ld_fwait2");
    add(8'h40, 0, 1, FR,  1, "ld_fetch");    add(8'h40, 0, 1, DEC, 1, "ld_decode");
    add(8'h40, 0, 1, EX,  1, "ld_exec");     add(8'h40, 0, 0, MRD, 1, "ld_mwait");
    add(8'h40, 0, 1, MRD, 1, "ld_mem");      add(8'h40, 0, 1, WBL, 1, "ld_wb");
    add(8'h41, 0, 1, FR,  2, "st_fetch");    add(8'h41, 0, 1, DEC, 2, "st_decode");
    add(8'h41, 0, 1, EX,  2, "st_exec");     add(8'h41, 0, 1, MWR, 2, "st_mem");
    add(8'h60, 1, 1, FR,  3, "bt_fetch");    add(8'h60, 1, 1, DEC, 3, "bt_decode");
    add(8'h60, 1, 1, BRT, 3, "bt_branch");   add(8'h60, 0, 1, FR,  4, "bn_fetch");
    add(8'h60, 0, 1, DEC, 4, "bn_decode");   add(8'h60, 0, 1, BRN, 4, "bn_branch");
    add(8'h80, 0, 1, FR,  5, "bl_fetch");    add(8'h80, 0, 1, DEC, 5, "bl_decode");
    add(8'h80, 0, 1, LNK, 5, "bl_link");     add(8'hA0, 0, 1, FR,  6, "hlt_fetch");
    add(8'hA0, 0, 1, DEC, 6, "hlt_decode");  add(8'hA0, 0, 0, HLT, 7, "halted");
    add(8'hA0, 0, 1, HLT, 7, "halt_ready");  add(8'h01, 0, 1, HLT, 7, "halt_sticky");
    run_tbl();

    // Illegal opcode
    do_reset();
    add(8'hC0, 0, 1, FR,  0, "ill_fetch");   add(8'hC0, 0, 1, DEC, 0, "ill_decode");
    add(8'hC0, 0, 1, ERI, 0, "ill_error");   add(8'h01, 0, 1, ERI, 0, "ill_sticky");
    run_tbl();

    // Fetch timeout after the 15th waiting cycle
    do_reset();
    for (int i = 0; i < 15; i++) add(8'h01, 0, 0, FW, 0, "to_wait");
    add(8'h01, 0, 1, ERM, 0, "to_error");    add(8'h01, 0, 1, ERM, 0, "to_sticky");
    run_tbl();

    // Ready in the 15th waiting cycle is accepted
    do_reset();
    for (int i = 0; i < 14; i++) add(8'h01, 0, 0, FW, 0, "late_wait");
    add(8'h01, 0, 1, FR,  0, "late_fetch");  add(8'h01, 0, 1, DEC, 0, "late_decode");
    add(8'h01, 0, 1, EX,  0, "late_exec");   add(8'h01, 0, 1, WBA, 0, "late_wb");
    add(8'h01, 0, 0, FW,  1, "late_next");
    run_tbl();

    // Reset in the middle of a load's MEM phase
    do_reset();
    add(8'h01, 0, 1, FR,  0, "pre_fetch");   add(8'h01, 0, 1, DEC, 0, "pre_decode");
    add(8'h01, 0, 1, EX,  0, "pre_exec");    add(8'h01, 0, 1, WBA, 0, "pre_wb");
    add(8'h40, 0, 1, FR,  1, "rl_fetch");    add(8'h40, 0, 1, DEC, 1, "rl_decode");
    add(8'h40, 0, 1, EX,  1, "rl_exec");     add(8'h40, 0, 0, MRD, 1, "rl_mwait");
    run_tbl();
    rst = 1'b1;
    #1;
    check("rst_mid_mem", 13'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    add(8'h40, 0, 0, FW, 0, "rst_fetch");
    run_tbl();

    // Saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      add(8'h01, 0, 1, FR,  i, "sat_fetch"); add(8'h01, 0, 1, DEC, i, "sat_decode");
      add(8'h01, 0, 1, EX,  i, "sat_exec");  add(8'h01, 0, 1, WBA, i, "sat_wb");
    end
    add(8'h01, 0, 0, FW, 17, "sat_end");
    run_tbl();
    n_tests++;
    if (s_instr_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_cnt4: count=%0d, required 15", s_instr_count);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kgprisc_multicycle_sequencer.md
Name: kgprisc_multicycle_sequencer

Overview:
Multi-cycle instruction sequencer for the KGPRISC core. It steps each instruction through fetch, decode, execute, memory and writeback. It gates the combinational Control unit's outputs into per-stage strobes and handshakes with a shared instruction/data memory port that may insert wait states. It also counts retired instructions and traps illegal opcodes and memory timeouts.

Parameters:
CNT_W, 16, width of retired-instruction counter
MAX_WAIT, 15, max consecutive cycles waiting on mem_ready before error (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  8  instruction register opcode (valid from DECODE onward)
branch_taken  in  1  branch condition from ALU flags, sampled in BRANCH
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write enable for the data access
mem_addr_sel  out  1  0 = PC address, 1 = ALU result address
ir_write  out  1  load instruction register
pc_incr  out  1  PC <= PC + 1
pc_load  out  1  PC <= branch target
alu_en  out  1  ALU result register capture
reg_write_en  out  1  register file write strobe
mem_to_reg  out  1  writeback source is memory
link_sel  out  1  writeback data/dest is link (PC)
halted  out  1  sequencer stopped
illegal_op  out  1  sticky: stopped on illegal opcode
mem_err  out  1  sticky: stopped on memory timeout
instr_count  out  CNT_W  retired instructions

Behaviour:
- Opcode class = opcode[7:5]:
  - 000 ALU register (0x01-0x06) and 001 ALU immediate (0x20-0x24) form the ALU class.
  - 010 is load (0x40) / store (0x41); store = opcode[0].
  - 011 is conditional branch (0x60-0x63).
  - 100 is branch-and-link (0x80-0x82).
  - 101 is halt (0xA0).
  - 110 and 111 are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, LINK, HALT, ERROR. Encoding is free.
- Reset (async): state = FETCH, instr_count = 0, illegal_op = mem_err = 0, wait counter = 0.
- Outputs are Moore decodes of state except ir_write and pc_incr, which are combinational on mem_ready in FETCH. During reset every output is 0.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0, mem_we = 0.
  - If mem_ready: ir_write = pc_incr = 1, next state DECODE.
- DECODE (1 cycle), next state by class:
  - ALU or ld/st -> EXEC
  - 011 -> BRANCH
  - 100 -> LINK
  - 101 -> HALT
  - 110/111 -> ERROR with illegal_op set
- EXEC (1 cycle): alu_en = 1. Next state is MEM for ld/st, otherwise WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = opcode[0].
  - On mem_ready: store retires -> FETCH; load -> WB.
- WB (1 cycle): reg_write_en = 1, mem_to_reg = (class==010). Retire -> FETCH.
- BRANCH (1 cycle): pc_load = branch_taken. Retire -> FETCH.
- LINK (1 cycle): reg_write_en = 1, link_sel = 1, pc_load = 1. Retire -> FETCH. Link captures the already-incremented PC.
- HALT: halted = 1. The halt instruction is retired (counted once on entering HALT). Terminal until rst.
- ERROR: halted = 1, not counted. Terminal until rst.
- Retire: instr_count += 1 on the retiring cycle; saturates at 2^CNT_W-1, no wrap.
- Wait counter:
  - Counts cycles in FETCH/MEM with mem_ready = 0 and clears on any state change.
  - When it reaches MAX_WAIT with mem_ready still 0, the next state is ERROR and mem_err is set.
  - mem_ready arriving in the MAX_WAIT-th waiting cycle is accepted normally; completion has priority over timeout.
- Zero-wait latency: ALU 4, load 5, store 4, branch 3, link 3 cycles.
- mem_ready outside FETCH/MEM is ignored.
- pc_incr and pc_load are never asserted in the same cycle.
- rst mid-instruction aborts it: no retire, no pending strobe.

Test Plan:
- ALU op 0x01, mem_ready tied 1 -> states FETCH, DECODE, EXEC, WB; reg_write_en high in cycle 4 only; instr_count 0 -> 1.
- Load 0x40 with 2 wait states in FETCH and 1 in MEM -> mem_req high 3 + 2 cycles; mem_addr_sel = 1 only in MEM; mem_to_reg = 1 in WB; total 8 cycles.
- Store 0x41 -> mem_we = 1 only in MEM; no reg_write_en; retires on MEM mem_ready. Branch 0x60 run twice (branch_taken = 1 then 0) -> pc_load 1 then 0, 3 cycles each.
- BL 0x80 -> LINK cycle shows reg_write_en = link_sel = pc_load = 1; then 0xA0 -> halted = 1; instr_count = 2; later mem_ready pulses have no effect.
- Opcode 0xC0 -> ERROR, illegal_op = 1, halted = 1, count unchanged. mem_ready held 0 in FETCH with MAX_WAIT = 15 -> mem_err after the 15th wait cycle. A second run with mem_ready on wait cycle 15 -> no error.
- Assert rst during MEM of a load -> outputs 0 immediately, state FETCH, count 0. With CNT_W = 4, run 17 ALU ops -> instr_count stays 15.
